// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: fixed-latency data memory responder with byte/half/word access and error flagging.
module data_mem_ctrl #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        err
);
  localparam int IW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic c_rd, c_wr;
  logic [2:0] c_f3;
  logic [31:0] c_addr, c_wd;
  logic [31:0] mem [DEPTH_WORDS] = '{default: '0};
  logic acc, fire, oor, bad, w_en;
  logic [31:0] word, ld, mask, wsh;
  logic [15:0] lane;
  logic [4:0] bsh;
  always_comb begin
    acc = state == IDLE && (mem_read || mem_write);
    fire = state == WAIT && cnt == '0;
    oor = {2'b00, c_addr[31:2]} >= 32'(DEPTH_WORDS);
    // misaligned half/word and illegal encodings all collapse into one error flag
    bad = (c_rd && c_wr) || (c_rd && (c_f3 == 3'b011 || c_f3[2:1] == 2'b11)) ||
          (c_wr && c_f3 > 3'b010) || (c_f3[1:0] == 2'b01 && c_addr[0]) ||
          (c_f3[1:0] == 2'b10 && c_addr[1:0] != 2'b00) || oor;
    word = mem[c_addr[IW+1:2]];
    bsh = {c_addr[1:0], 3'b000};
    lane = 16'(word >> bsh);
    ld = c_f3 == 3'b000 ? {{24{lane[7]}}, lane[7:0]} :
         c_f3 == 3'b001 ? {{16{lane[15]}}, lane} :
         c_f3 == 3'b100 ? {24'b0, lane[7:0]} :
         c_f3 == 3'b101 ? {16'b0, lane} : word;
    mask = (c_f3[1:0] == 2'b00 ? 32'h0000_00FF : c_f3[1:0] == 2'b01 ? 32'h0000_FFFF : 32'hFFFF_FFFF) << bsh;
    wsh = c_wd << bsh;
    w_en = fire && c_wr && !bad && !rst;
    state_n = state;
    state_n = acc ? WAIT : fire ? DONE : state == DONE ? IDLE : state;
  end
  always_ff @(posedge clk)
    if (w_en) mem[c_addr[IW+1:2]] <= (word & ~mask) | (wsh & mask);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      c_rd <= 1'b0;
      c_wr <= 1'b0;
      c_f3 <= '0;
      c_addr <= '0;
      c_wd <= '0;
      rdata <= '0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      if (acc) begin
        c_rd <= mem_read;
        c_wr <= mem_write;
        c_f3 <= funct3;
        c_addr <= addr;
        c_wd <= wdata;
        cnt <= CW'(LATENCY - 1);
      end else if (state == WAIT && !fire) cnt <= cnt - 1'b1;
      if (fire) begin
        rdata <= (bad || c_wr) ? '0 : ld;
        err <= bad;
      end else if (state == DONE) begin
        rdata <= '0;
        err <= 1'b0;
      end
    end
  end
  assign ready = state == DONE;
  assign busy = state != IDLE;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: scoreboard bench for data_mem_ctrl at LATENCY=2 and LATENCY=1.
module tb_data_mem_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic rd0 = 0, wr0 = 0, rd1 = 0, wr1 = 0;
  logic [2:0] f30 = 0, f31 = 0;
  logic [31:0] a0 = 0, wd0 = 0, a1 = 0, wd1 = 0;
  logic [31:0] rdata0, rdata1;
  logic ready0, busy0, err0, ready1, busy1, err1;
  typedef struct {logic [31:0] rd; logic er; int due;} exp_t;
  exp_t q0[$], q1[$];
  exp_t e0, e1;
  int cyc = 0, checks = 0, failures = 0;

  data_mem_ctrl #(.DEPTH_WORDS(256), .LATENCY(2)) u_dut (
    .clk(clk), .rst(rst), .mem_read(rd0), .mem_write(wr0), .funct3(f30), .addr(a0), .wdata(wd0),
    .rdata(rdata0), .ready(ready0), .busy(busy0), .err(err0));
  data_mem_ctrl #(.DEPTH_WORDS(256), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .mem_read(rd1), .mem_write(wr1), .funct3(f31), .addr(a1), .wdata(wd1),
    .rdata(rdata1), .ready(ready1), .busy(busy1), .err(err1));

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) if (!rst) begin
    if (ready0) begin
      if (q0.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_ready0 actual=1 required=0 at cycle %0d", cyc);
      end else begin
        e0 = q0.pop_front();
        chk("rdata0", rdata0, e0.rd);
        chk("err0", {31'b0, err0}, {31'b0, e0.er});
        chk("latency0", 32'(cyc), 32'(e0.due));
      end
    end
    if (ready1) begin
      if (q1.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_ready1 actual=1 required=0 at cycle %0d", cyc);
      end else begin
        e1 = q1.pop_front();
        chk("rdata1", rdata1, e1.rd);
        chk("err1", {31'b0, err1}, {31'b0, e1.er});
        chk("latency1", 32'(cyc), 32'(e1.due));
      end
    end
  end

  task automatic issue0(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] xrd, input logic xer);
    rd0 = rd; wr0 = wr; f30 = f3; a0 = a; wd0 = wd;
    q0.push_back('{xrd, xer, cyc + 3});
    @(negedge clk);
    rd0 = 0; wr0 = 0;
    chk("busy_wait", {31'b0, busy0}, 32'd1);
    repeat (2) @(negedge clk);
    chk("busy_done", {31'b0, busy0}, 32'd1);
    @(negedge clk);
    chk("busy_idle", {31'b0, busy0}, 32'd0);
  endtask

  task automatic issue1(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] xrd, input logic xer);
    rd1 = rd; wr1 = wr; f31 = f3; a1 = a; wd1 = wd;
    q1.push_back('{xrd, xer, cyc + 2});
    @(negedge clk);
    rd1 = 0; wr1 = 0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_rdata", rdata0, 32'h0);
    chk("rst_flags", {28'b0, ready0, busy0, err0, ready1}, 32'h0);
    rst = 0;
    @(negedge clk);
    issue0(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0);
    issue0(1, 0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0);
    issue0(0, 1, 3'b000, 32'h21, 32'h12345680, 32'h0, 0);
    issue0(1, 0, 3'b000, 32'h21, 32'h0, 32'hFFFFFF80, 0);
    issue0(1, 0, 3'b100, 32'h21, 32'h0, 32'h00000080, 0);
    issue0(1, 0, 3'b010, 32'h20, 32'h0, 32'h00008000, 0);
    issue0(0, 1, 3'b001, 32'h12, 32'hABCD8001, 32'h0, 0);
    issue0(1, 0, 3'b001, 32'h12, 32'h0, 32'hFFFF8001, 0);
    issue0(1, 0, 3'b101, 32'h12, 32'h0, 32'h00008001, 0);
    issue0(1, 0, 3'b001, 32'h13, 32'h0, 32'h0, 1);
    issue0(1, 0, 3'b010, 32'h10, 32'h0, 32'h8001BEEF, 0);
    issue0(0, 1, 3'b010, 32'h40, 32'h11223344, 32'h0, 0);
    issue0(0, 1, 3'b010, 32'h41, 32'hFFFFFFFF, 32'h0, 1);
    issue0(0, 1, 3'b001, 32'h43, 32'hFFFFFFFF, 32'h0, 1);
    issue0(1, 0, 3'b010, 32'h400, 32'h0, 32'h0, 1);
    issue0(0, 1, 3'b010, 32'h400, 32'hFFFFFFFF, 32'h0, 1);
    issue0(1, 1, 3'b010, 32'h40, 32'hFFFFFFFF, 32'h0, 1);
    issue0(0, 1, 3'b011, 32'h40, 32'hFFFFFFFF, 32'h0, 1);
    issue0(1, 0, 3'b011, 32'h40, 32'h0, 32'h0, 1);
    issue0(1, 0, 3'b110, 32'h40, 32'h0, 32'h0, 1);
    issue0(1, 0, 3'b010, 32'h3FC, 32'h0, 32'h0, 0);
    issue0(0, 1, 3'b010, 32'h3FC, 32'hA5A5A5A5, 32'h0, 0);
    issue0(1, 0, 3'b010, 32'h3FC, 32'h0, 32'hA5A5A5A5, 0);
    // a second LW presented while busy must be dropped
    rd0 = 1; f30 = 3'b010; a0 = 32'h40;
    q0.push_back('{32'h11223344, 1'b0, cyc + 3});
    @(negedge clk);
    a0 = 32'h10;
    repeat (2) @(negedge clk);
    rd0 = 0;
    @(negedge clk);
    repeat (2) @(negedge clk);
    // reset during WAIT discards the pending store
    wr0 = 1; f30 = 3'b010; a0 = 32'h30; wd0 = 32'h12345678;
    @(negedge clk);
    wr0 = 0;
    chk("abort_busy_before", {31'b0, busy0}, 32'd1);
    rst = 1;
    #1;
    chk("abort_rdata", rdata0, 32'h0);
    chk("abort_flags", {29'b0, ready0, busy0, err0}, 32'h0);
    @(negedge clk);
    rst = 0;
    repeat (3) @(negedge clk);
    issue0(1, 0, 3'b010, 32'h30, 32'h0, 32'h0, 0);
    issue0(1, 0, 3'b010, 32'h10, 32'h0, 32'h8001BEEF, 0);
    issue1(0, 1, 3'b010, 32'h10, 32'hCAFEF00D, 32'h0, 0);
    rd1 = 1; f31 = 3'b010; a1 = 32'h10;
    for (int i = 0; i < 4; i++) q1.push_back('{32'hCAFEF00D, 1'b0, cyc + 2 + 3 * i});
    repeat (12) @(negedge clk);
    rd1 = 0;
    for (int i = 0; i < 20 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
    chk("pending_responses", 32'(q0.size() + q1.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
